// File: rtl/rr_arb_mux.sv
// N-input registered multiplexer with valid/ready handshakes.
// The channel is chosen either by a fixed select or by round-robin arbitration.
module rr_arb_mux #(
    parameter  int N_IN  = 4,
    parameter  int WIDTH = 32,
    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic [N_IN-1:0]         in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic                load;
    logic [N_IN-1:0]     grant;
    logic [N_IN-1:0]     rot;
    logic                found;
    int unsigned         off;
    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    ptr_nxt;
    logic [SEL_W-1:0]    gnt_idx;
    logic [WIDTH-1:0]    gnt_data;

    assign load = !out_valid || out_ready;

    // Rotating the valids by ptr turns the wrapped scan into a plain lowest-set-bit search.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        gnt_data = '0;
        ptr_nxt  = ptr;
        found    = 1'b0;
        off      = 0;
        rot      = N_IN'({in_valid, in_valid} >> ptr);
        if (!mode) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (32'(sel) == i) grant[i] = in_valid[i];
            end
        end else begin
            for (int unsigned j = 0; j < N_IN; j++) begin
                if (!found && rot[j]) begin
                    found = 1'b1;
                    off   = j;
                end
            end
            if (found) begin
                for (int unsigned i = 0; i < N_IN; i++) begin
                    if (i == (32'(ptr) + off) % N_IN) grant[i] = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                gnt_idx  = SEL_W'(i);
                gnt_data = in_data[i*WIDTH +: WIDTH];
                ptr_nxt  = SEL_W'((i + 1) % N_IN);
            end
        end
    end

    assign in_ready = rst_n ? (grant & {N_IN{load}}) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= |grant;
            if (|grant) begin
                out_data <= gnt_data;
                out_src  <= gnt_idx;
                if (mode) ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel instance plus a 3-channel one
// that exercises an out-of-range select.
module tb_rr_arb_mux;

    logic         clk = 1'b0;
    logic         rst_n;
    int           tests = 0;
    int           fails = 0;

    // 4-channel instance
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_src;
    logic [31:0]  dv [4];

    // 3-channel instance
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic         mode3;
    logic [1:0]   sel3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic [1:0]   out_src3;

    always #5 clk = ~clk;

    rr_arb_mux #(.N_IN(4), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
    );

    rr_arb_mux #(.N_IN(3), .WIDTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_src(out_src3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 4'hF; out_ready = 1'b1; mode = 1'b1; sel = 2'd0;
        repeat (3) step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL release_in_ready: got %b expected 0001", in_ready); end
        step();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL release_out_valid: got %b expected 1", out_valid); end
        tests++; if (out_src !== 2'd0) begin fails++; $display("FAIL release_out_src: got %0d expected 0", out_src); end
        tests++; if (out_data !== dv[0]) begin fails++; $display("FAIL release_out_data: got %h expected %h", out_data, dv[0]); end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL fixed_in_ready: got %b expected 0100", in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fixed_valid[%0d]: got %b expected 1", k, out_valid); end
            tests++; if (out_src !== 2'd2) begin fails++; $display("FAIL fixed_src[%0d]: got %0d expected 2", k, out_src); end
            tests++; if (out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL fixed_data[%0d]: got %h expected deadbeef", k, out_data); end
            tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL fixed_ready[%0d]: got %b expected 0100", k, in_ready); end
        end
    endtask

    task automatic test_rr_fairness();
        logic [3:0] exp_rdy;
        rst_n = 1'b0;
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rr_reset_valid: got %b expected 0", out_valid); end
        #2;
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL rr_first_ready: got %b expected 0001", in_ready); end
        for (int k = 0; k < 8; k++) begin
            step();
            exp_rdy = 4'b0001 << ((k + 1) % 4);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d]: got %b expected 1", k, out_valid); end
            tests++; if (out_src !== 2'(k % 4)) begin fails++; $display("FAIL rr_src[%0d]: got %0d expected %0d", k, out_src, k % 4); end
            tests++; if (out_data !== dv[k % 4]) begin fails++; $display("FAIL rr_data[%0d]: got %h expected %h", k, out_data, dv[k % 4]); end
            tests++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy); end
        end
    endtask

    task automatic test_rr_sparse();
        logic [1:0] exp_src [3];
        logic [3:0] exp_rdy [3];
        exp_src[0] = 2'd3; exp_src[1] = 2'd1; exp_src[2] = 2'd3;
        exp_rdy[0] = 4'b0010; exp_rdy[1] = 4'b1000; exp_rdy[2] = 4'b0010;
        // A lone ch1 transfer moves the pointer to 2.
        in_valid = 4'b0010;
        #1;
        tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL sparse_setup_ready: got %b expected 0010", in_ready); end
        step();
        tests++; if (out_src !== 2'd1) begin fails++; $display("FAIL sparse_setup_src: got %0d expected 1", out_src); end
        in_valid = 4'b1010;
        #1;
        tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL sparse_ready_ptr2: got %b expected 1000", in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (out_src !== exp_src[k]) begin fails++; $display("FAIL sparse_src[%0d]: got %0d expected %0d", k, out_src, exp_src[k]); end
            tests++; if (out_data !== dv[exp_src[k]]) begin fails++; $display("FAIL sparse_data[%0d]: got %h expected %h", k, out_data, dv[exp_src[k]]); end
            tests++; if (in_ready !== exp_rdy[k]) begin fails++; $display("FAIL sparse_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy[k]); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 4'b0001;
        #1;
        tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready_start: got %b expected 0000", in_ready); end
        for (int k = 0; k < 5; k++) begin
            step();
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, out_valid); end
            tests++; if (out_src !== 2'd3) begin fails++; $display("FAIL bp_src[%0d]: got %0d expected 3", k, out_src); end
            tests++; if (out_data !== dv[3]) begin fails++; $display("FAIL bp_data[%0d]: got %h expected %h", k, out_data, dv[3]); end
            tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL bp_release_ready: got %b expected 0001", in_ready); end
        step();
        tests++; if (out_src !== 2'd0) begin fails++; $display("FAIL bp_release_src: got %0d expected 0", out_src); end
        tests++; if (out_data !== dv[0]) begin fails++; $display("FAIL bp_release_data: got %h expected %h", out_data, dv[0]); end
        in_valid = 4'b0000;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_illegal_sel();
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1;
        tests++; if (in_ready3 !== 3'b000) begin fails++; $display("FAIL illegal_ready: got %b expected 000", in_ready3); end
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL illegal_valid[%0d]: got %b expected 0", k, out_valid3); end
        end
        sel3 = 2'd2;
        #1;
        tests++; if (in_ready3 !== 3'b100) begin fails++; $display("FAIL sel3_ready: got %b expected 100", in_ready3); end
        step();
        tests++; if (out_src3 !== 2'd2) begin fails++; $display("FAIL sel3_src: got %0d expected 2", out_src3); end
        tests++; if (out_data3 !== 32'hC0DE_0002) begin fails++; $display("FAIL sel3_data: got %h expected c0de0002", out_data3); end
        in_valid3 = 3'b000;
    endtask

    task automatic test_async_reset();
        // Main instance pointer is 1 here (last transfer was ch0 in round-robin).
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        step();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_valid: got %b expected 1", out_valid); end
        tests++; if (out_src !== 2'd1) begin fails++; $display("FAIL mid_src: got %0d expected 1", out_src); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_valid: got %b expected 0", out_valid); end
        tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL async_ready: got %b expected 0000", in_ready); end
        #2;
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL async_ptr_ready: got %b expected 0001", in_ready); end
        step();
        tests++; if (out_src !== 2'd0) begin fails++; $display("FAIL async_ptr_src: got %0d expected 0", out_src); end
    endtask

    initial begin
        dv[0] = 32'h1111_1111; dv[1] = 32'h2222_2222;
        dv[2] = 32'hDEAD_BEEF; dv[3] = 32'h4444_4444;
        in_data  = {dv[3], dv[2], dv[1], dv[0]};
        in_data3 = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        in_valid3 = 3'b000; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
        test_reset();
        test_fixed();
        test_rr_fairness();
        test_rr_sparse();
        test_backpressure();
        test_illegal_sel();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
